// File: rtl/jtdd2_snd_pkg.sv
// Shared types and constants for the JTDD2 sound subsystem.
// Used by the ADPCM ROM cache and its line storage.
package jtdd2_snd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    localparam int LINE_BYTES = 8;
    localparam int LINE_WORDS = 4;

    function automatic int tag_w(input int aw, input int lw);
        return aw - lw - 1;
    endfunction

endpackage

// File: rtl/jtdd2_adpcm_line.sv
// One ADPCM cache line: tag, valid bit, word array,
// write port and hit compare.
module jtdd2_adpcm_line
    import jtdd2_snd_pkg::*;
#(
    parameter int AW = 18,
    parameter int LW = 2,
    localparam int TW = tag_w(AW, LW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          set_i,
    input  logic          we_i,
    input  logic [LW-1:0] wsel_i,
    input  logic [15:0]   wdata_i,
    input  logic [TW-1:0] wtag_i,
    input  logic [TW-1:0] tag_i,
    input  logic [LW-1:0] rsel_i,
    output logic          hit_o,
    output logic [15:0]   rdata_o
);
    localparam int NW = 1 << LW;

    logic          valid_q;
    logic [TW-1:0] tag_q;
    logic [15:0]   words_q [NW];

    // Valid goes low when picked as victim, high once filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (set_i) begin
            valid_q <= 1'b1;
            tag_q   <= wtag_i;
        end
    end

    // Word storage, written one SDRAM word at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                words_q[i] <= '0;
            end
        end else if (we_i) begin
            words_q[wsel_i] <= wdata_i;
        end
    end

    assign hit_o   = valid_q && (tag_q == tag_i);
    assign rdata_o = words_q[rsel_i];

endmodule

// File: rtl/jtdd2_adpcm_cache.sv
// Two-line read cache between the ADPCM ROM port
// and the shared SDRAM ROM slot.
module jtdd2_adpcm_cache
    import jtdd2_snd_pkg::*;
#(
    parameter int AW = 18,
    parameter int LW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [7:0]    data,
    output logic          ok,
    output logic [AW-2:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_dok,
    input  logic [15:0]   sdram_data
);
    localparam int TW = tag_w(AW, LW);

    state_t        state_q, state_d;
    logic [LW-1:0] wc_q, wc_d;
    logic [TW-1:0] btag_q, btag_d;
    logic          vict_q, vict_d;
    logic          lru_q, lru_d;
    logic          okr_q, okr_d;
    logic [7:0]    data_q, data_d;
    logic [AW-1:0] addrl_q, addrl_d;

    logic [TW-1:0] tag;
    logic [1:0]    hit, clr, set, we;
    logic [15:0]   rdata [2];
    logic [15:0]   word;
    logic          wr;

    assign tag = addr[AW-1:LW+1];

    for (genvar i = 0; i < 2; i++) begin : g_line
        jtdd2_adpcm_line #(.AW(AW), .LW(LW)) u_line (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (clr[i]),
            .set_i   (set[i]),
            .we_i    (we[i]),
            .wsel_i  (wc_q),
            .wdata_i (sdram_data),
            .wtag_i  (btag_q),
            .tag_i   (tag),
            .rsel_i  (addr[LW:1]),
            .hit_o   (hit[i]),
            .rdata_o (rdata[i])
        );
    end

    // Lookup, victim selection and line fill sequencing.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        btag_d  = btag_q;
        vict_d  = vict_q;
        lru_d   = lru_q;
        okr_d   = okr_q;
        data_d  = data_q;
        addrl_d = addrl_q;
        clr     = '0;
        set     = '0;
        we      = '0;
        wr      = 1'b0;
        word    = hit[1] ? rdata[1] : rdata[0];
        unique case (state_q)
            IDLE: begin
                if (cs && |hit) begin
                    data_d  = addr[0] ? word[15:8]
                                      : word[7:0];
                    addrl_d = addr;
                    okr_d   = 1'b1;
                    lru_d   = hit[0];
                end else if (cs) begin
                    clr[lru_q] = 1'b1;
                    vict_d  = lru_q;
                    lru_d   = ~lru_q;
                    btag_d  = tag;
                    wc_d    = '0;
                    okr_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    state_d = WAIT;
                    wr      = sdram_dok;
                end
            end
            WAIT: wr = sdram_dok;
            default: state_d = IDLE;
        endcase
        // A word arriving in REQ (with ack) counts as if from WAIT.
        if (wr) begin
            we[vict_q] = 1'b1;
            if (wc_q == '1) begin
                set[vict_q] = 1'b1;
                state_d = IDLE;
            end else begin
                wc_d    = wc_q + 1'b1;
                state_d = REQ;
            end
        end
    end

    // State register; reset drops sdram_req at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wc_q    <= '0;
            btag_q  <= '0;
            vict_q  <= 1'b0;
            lru_q   <= 1'b0;
            okr_q   <= 1'b0;
            data_q  <= '0;
            addrl_q <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            btag_q  <= btag_d;
            vict_q  <= vict_d;
            lru_q   <= lru_d;
            okr_q   <= okr_d;
            data_q  <= data_d;
            addrl_q <= addrl_d;
        end
    end

    assign data       = data_q;
    assign ok         = okr_q && cs && (addr == addrl_q);
    assign sdram_req  = (state_q == REQ);
    assign sdram_addr = {btag_q, wc_q};

endmodule

// File: tb/tb_jtdd2_adpcm_cache.sv
// Self-checking bench for jtdd2_adpcm_cache with an
// SDRAM responder and a list-based LRU reference model.
module tb_jtdd2_adpcm_cache;
    import jtdd2_snd_pkg::*;

    localparam int AW = 18;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [7:0]    data;
    logic          ok;
    logic [AW-2:0] sdram_addr;
    logic          sdram_req;
    logic          sdram_ack = 1'b0;
    logic          sdram_dok = 1'b0;
    logic [15:0]   sdram_data = '0;

    int pass_n = 0;
    int total_n = 0;

    jtdd2_adpcm_cache #(.AW(AW), .LW(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .addr       (addr),
        .data       (data),
        .ok         (ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_data (sdram_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] memw(input logic [AW-2:0] w);
        case (w)
            17'h8:   return 16'h1122;
            17'h9:   return 16'h3344;
            17'hA:   return 16'h5566;
            17'hB:   return 16'h7788;
            default: return 16'((w * 32'd40503) ^ (w >> 5));
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
        logic [15:0] wd;
        wd = memw(a[AW-1:1]);
        return a[0] ? wd[15:8] : wd[7:0];
    endfunction

    // Reference: most-recent-first list of resident line numbers.
    int mlines[$];

    function automatic int model_access(input logic [AW-1:0] a);
        int t;
        int idx;
        t = int'(a) / LINE_BYTES;
        idx = -1;
        foreach (mlines[i]) if (mlines[i] == t) idx = i;
        if (idx >= 0) begin
            mlines.delete(idx);
            mlines.push_front(t);
            return 0;
        end
        mlines.push_front(t);
        if (mlines.size() > 2) void'(mlines.pop_back());
        return 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // SDRAM responder
    int          req_cnt = 0;
    int          dok_cnt = 0;
    int          last_dok_cyc = 0;
    logic [AW-2:0] req_q[$];
    bit          pend = 0;
    int          dly = 0;
    logic [AW-2:0] paddr = '0;
    bit          same_mode = 0;
    int          fix_dly = -1;
    int          spur_req = 0;
    int          spur_done = 0;

    initial forever begin
        @(negedge clk);
        sdram_ack = 1'b0;
        sdram_dok = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else if (spur_done != spur_req) begin
            sdram_dok  = 1'b1;
            sdram_data = 16'hDEAD;
            spur_done++;
        end else if (pend) begin
            if (dly == 0) begin
                sdram_dok  = 1'b1;
                sdram_data = memw(paddr);
                pend = 0;
                dok_cnt++;
                last_dok_cyc = cyc;
            end else begin
                dly--;
            end
        end else if (sdram_req) begin
            sdram_ack = 1'b1;
            req_cnt++;
            req_q.push_back(sdram_addr);
            if (same_mode) begin
                sdram_dok  = 1'b1;
                sdram_data = memw(sdram_addr);
                dok_cnt++;
                last_dok_cyc = cyc;
            end else begin
                pend  = 1;
                paddr = sdram_addr;
                dly   = (fix_dly >= 0) ? fix_dly
                                       : int'($urandom_range(0, 3));
            end
        end
    end

    int ok_cyc = 0;

    task automatic wait_ok(input string name, output int cycles);
        cycles = 0;
        while (!ok && cycles < 200) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        ok_cyc = cyc;
        if (cycles >= 200) chk({name, " ok timeout"}, int'(ok), 1);
    endtask

    task automatic do_read(input string name,
                           input logic [AW-1:0] a,
                           input int exp_reqs);
        int r0, cy, e;
        r0 = req_cnt;
        e = model_access(a);
        if (exp_reqs >= 0) e = exp_reqs;
        addr = a;
        cs = 1'b1;
        #1;
        chk({name, " ok low on step"}, int'(ok), 0);
        wait_ok(name, cy);
        chk({name, " data"}, int'(data), int'(exp_byte(a)));
        chk({name, " reqs"}, req_cnt - r0, e);
        if (e == 0) chk({name, " hit latency"}, cy, 1);
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int r0, d0, cy, n, okhi;
        logic [AW-1:0] ra;

        tbl[0] = '{18'h11, 8'h11};
        tbl[1] = '{18'h12, 8'h44};
        tbl[2] = '{18'h13, 8'h33};
        tbl[3] = '{18'h14, 8'h66};
        tbl[4] = '{18'h15, 8'h55};
        tbl[5] = '{18'h16, 8'h88};
        tbl[6] = '{18'h17, 8'h77};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        chk("reset data", int'(data), 0);
        chk("reset ok", int'(ok), 0);
        chk("reset req", int'(sdram_req), 0);
        chk("reset sdram_addr", int'(sdram_addr), 0);

        // Cold read
        req_q.delete();
        do_read("cold", 18'h10, 4);
        chk("cold ok delay", ok_cyc - last_dok_cyc, 2);
        for (int i = 0; i < 4; i++) begin
            if (req_q.size() > i)
                chk("cold req addr", int'(req_q[i]), 8 + i);
            else
                chk("cold req count", req_q.size(), 4);
        end

        // Sequential hits
        for (int i = 0; i < 7; i++) begin
            r0 = req_cnt;
            void'(model_access(tbl[i].a));
            addr = tbl[i].a;
            #1;
            chk("seq step ok", int'(ok), 0);
            wait_ok("seq", cy);
            chk("seq latency", cy, 1);
            chk("seq data", int'(data), int'(tbl[i].d));
            chk("seq reqs", req_cnt - r0, 0);
        end

        // LRU replacement
        do_read("lru fill0", 18'h000, 4);
        do_read("lru fill1", 18'h100, 4);
        do_read("lru touch0", 18'h000, 0);
        do_read("lru fill2", 18'h200, 4);
        do_read("lru reread0", 18'h000, 0);
        do_read("lru reread1", 18'h100, 4);

        // ack and dok together
        same_mode = 1;
        do_read("same fill", 18'h301, 4);
        do_read("same hit", 18'h306, 0);
        same_mode = 0;

        // cs falls mid-fill
        r0 = req_cnt;
        d0 = dok_cnt;
        void'(model_access(18'h700));
        addr = 18'h700;
        cs = 1'b1;
        n = 0;
        while (req_cnt == r0 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        cs = 1'b0;
        okhi = 0;
        n = 0;
        while (dok_cnt < d0 + 4 && n < 200) begin
            @(negedge clk);
            #2;
            if (ok) okhi++;
            n++;
        end
        chk("csdrop fill done", dok_cnt - d0, 4);
        repeat (3) begin
            @(negedge clk);
            #2;
            if (ok) okhi++;
        end
        chk("csdrop ok stays low", okhi, 0);
        do_read("csdrop reread", 18'h703, 0);

        // Address change while waiting for data
        fix_dly = 3;
        req_q.delete();
        r0 = req_cnt;
        void'(model_access(18'h500));
        addr = 18'h500;
        cs = 1'b1;
        n = 0;
        while (!(req_cnt == r0 + 1 && !sdram_req) && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("move in wait", int'(sdram_req), 0);
        void'(model_access(18'h600));
        addr = 18'h600;
        #1;
        chk("move ok low", int'(ok), 0);
        wait_ok("move", cy);
        chk("move data", int'(data), int'(exp_byte(18'h600)));
        chk("move reqs", req_cnt - r0, 8);
        if (req_q.size() >= 5) begin
            chk("move first base", int'(req_q[0]), 18'h280);
            chk("move second base", int'(req_q[4]), 18'h300);
        end else begin
            chk("move req count", req_q.size(), 8);
        end
        do_read("move old kept", 18'h502, 0);

        // Reset during a fill
        fix_dly = 2;
        d0 = dok_cnt;
        void'(model_access(18'h405));
        addr = 18'h405;
        cs = 1'b1;
        n = 0;
        while (dok_cnt < d0 + 2 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        @(posedge clk);
        #2;
        chk("rst pre req", int'(sdram_req), 1);
        rst_n = 1'b0;
        #1;
        chk("rst req drop", int'(sdram_req), 0);
        chk("rst ok", int'(ok), 0);
        cs = 1'b0;
        mlines.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        spur_req++;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("spurious dok idle", int'(sdram_req), 0);
        fix_dly = -1;
        req_q.delete();
        do_read("rst refetch", 18'h405, 4);
        if (req_q.size() > 0)
            chk("rst refetch base", int'(req_q[0]), 18'h200);
        else
            chk("rst refetch count", req_q.size(), 4);

        // Randomized reads against the model
        for (int i = 0; i < 40; i++) begin
            same_mode = ($urandom_range(0, 3) == 0);
            do begin
                ra = 18'h800 + 18'(8 * $urandom_range(0, 4))
                             + 18'($urandom_range(0, 7));
            end while (ra == addr);
            if ($urandom_range(0, 4) == 0) begin
                cs = 1'b0;
                #1;
                chk("rand cs low ok", int'(ok), 0);
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    #2;
                end
            end
            do_read("rand", ra, -1);
        end
        same_mode = 0;

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
